instr_encoder: RTL
==================

# instr_encoder

Streaming RV32 immediate encoder, the inverse of the core's immediate extender. It takes a base instruction word plus a 32-bit signed immediate and an immediate type. It range-checks the immediate, packs it into the I/S/B bit positions, and queues the finished word with a sequential word address. The block sits between the test/boot program generator and the instruction-memory write port.

## Interface
- DEPTH, 4: output FIFO depth in entries; power of two, ≥2.
- ADDR_W, 10: width of the word-address counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input entry valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- imm_src  in  2  0 = I, 1 = S, 2 = B, 3 = reserved.
- imm  in  32  signed immediate value; B-type is a byte offset.
- base  in  32  instruction word; its immediate bit positions are ignored.
- addr_ld  in  1  load the address counter.
- addr_val  in  ADDR_W  address to load.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  head consumed when out_valid & out_ready.
- out_instr  out  32  encoded instruction at FIFO head.
- out_addr  out  ADDR_W  word address of the FIFO head.
- err  out  1  sticky range/type error flag.
- err_clr  in  1  synchronous clear of err.

## Operation
- Packing:
  - I-type: out[31:20] = imm[11:0].
  - S-type: out[31:25] = imm[11:5] and out[11:7] = imm[4:0].
  - B-type: out[31] = imm[12], out[30:25] = imm[10:5], out[11:8] = imm[4:1], out[7] = imm[11].
  - All other bits come from base. The immediate field positions of base are cleared before the merge.
- Range rules:
  - I/S: imm[31:11] must be all-equal.
  - B: imm[31:12] must be all-equal and imm[0] must be 0.
  - imm_src = 3 is always an error.
- Error handling:
  - An accepted entry that fails the range rules is dropped: no FIFO push and no address increment.
  - err is set the cycle after acceptance.
- Address counter:
  - Each pushed entry takes the current counter value; the counter then increments by 1 and wraps from 2^ADDR_W−1 to 0.
  - When addr_ld is asserted, an entry accepted in the same cycle takes addr_val, and the counter becomes addr_val+1 (or addr_val if no valid push).
- FIFO:
  - DEPTH entries, strict in-order. Each entry holds {out_instr, out_addr}.
  - in_ready = !full. There is no push-through when full, even if a pop happens the same cycle.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- err flag: err_clr and a new error in the same cycle leaves err = 1 (set wins).

## Timing
- Reset values (asynchronous, while rst_n is low):
  - FIFO empty; out_valid = 0, out_instr = 0, out_addr = 0.
  - Address counter = 0; err = 0; in_ready = 1 (driven as !full).
- Reset mid-operation discards all buffered entries immediately.
- Latency: an entry accepted at edge N is visible at the head by edge N+1 when the FIFO was empty (one cycle). There is no combinational path from in_* to out_*.
- out_instr and out_addr hold stable while out_valid & !out_ready.
- in_ready depends only on registered FIFO count. It has no combinational path from out_ready.

## Configuration
- Macro: ENCODER_CHECK_EN.
- When defined: range and type checking as above.
- When undefined:
  - No checking; err is tied to 0 and err_clr is ignored.
  - Immediates are truncated silently.
  - imm_src = 3 packs as I-type.
  - Every accepted entry is pushed.

## Test plan
- I-type: base=0x00000013, imm=0xFFFFFFFF, imm_src=0 → out_instr=0xFFF00013, out_addr=0, one cycle after acceptance.
- S-type: base=0x00002023, imm=0x000007FF, imm_src=1 → out_instr=0x7E002FA3. B-type: base=0x00000063, imm=0xFFFFFFFC, imm_src=2 → out_instr=0xFE000EE3, out_addr=1.
- Range error (check enabled): imm_src=0, imm=0x00000800 → no out_valid, err=1, next good entry gets the unadvanced address. err_clr=1 → err=0 next cycle. Repeat with B-type imm=0x3 → err=1.
- Backpressure: out_ready=0, push 5 entries → in_ready=0 after the 4th, 5th held. Then out_ready=1 → words drain in order with out_addr 0,1,2,3,4.
- Address load/wrap: ADDR_W=10, addr_ld with addr_val=0x3FF, push 2 → out_addr 0x3FF then 0x000.
- Reset mid-operation: 3 entries buffered, err=1, rst_n low for a partial cycle → out_valid=0, err=0 immediately. After release, next push gets out_addr=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV32 I/S/B immediate encoder with an in-order output FIFO and word-address tagging.
// Define ENCODER_CHECK_EN to enable immediate range/type checking and the sticky err flag.
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        imm_src,
  input  logic [31:0]       imm,
  input  logic [31:0]       base,
  input  logic              addr_ld,
  input  logic [ADDR_W-1:0] addr_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_cnt;

  logic [31:0]       enc_c;
  logic              imm_ok_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic [ADDR_W-1:0] push_addr_c;

  // Every immediate field bit is overwritten here, so base's field bits never leak through.
  always_comb begin
    enc_c = base;
    unique case (imm_src)
      2'd1: begin
        enc_c[31:25] = imm[11:5];
        enc_c[11:7]  = imm[4:0];
      end
      2'd2: begin
        enc_c[31]    = imm[12];
        enc_c[30:25] = imm[10:5];
        enc_c[11:8]  = imm[4:1];
        enc_c[7]     = imm[11];
      end
      default: enc_c[31:20] = imm[11:0];
    endcase
  end

`ifdef ENCODER_CHECK_EN
  // Sign-extension test: the bits above the field must all replicate the field's sign bit.
  always_comb begin
    imm_ok_c = 1'b0;
    unique case (imm_src)
      2'd0, 2'd1: imm_ok_c = (&imm[31:11]) | ~(|imm[31:11]);
      2'd2:       imm_ok_c = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      default:    imm_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept_c && !imm_ok_c) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_ok;
  assign imm_ok_c  = 1'b1;
  assign err       = 1'b0;
  assign unused_ok = ^{imm[31:13], err_clr};
`endif

  assign in_ready    = (count != CNT_W'(DEPTH));
  assign out_valid   = (count != CNT_W'(0));
  assign accept_c    = in_valid & in_ready;
  assign push_c      = accept_c & imm_ok_c;
  assign pop_c       = out_valid & out_ready;
  assign push_addr_c = addr_ld ? addr_val : addr_cnt;
  assign out_instr   = instr_mem[rd_ptr];
  assign out_addr    = addr_mem[rd_ptr];

  // Address counter: a load takes effect even when nothing is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (push_c) begin
      addr_cnt <= push_addr_c + ADDR_W'(1);
    end else if (addr_ld) begin
      addr_cnt <= addr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else begin
      if (push_c) begin
        instr_mem[wr_ptr] <= enc_c;
        addr_mem[wr_ptr]  <= push_addr_c;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
